vproc_elem_seq: RTL and testbench

// - Sequencer for the ELEM element-serial unit. Accepts one ELEM instruction descriptor at a time.
// - Emits one control beat per element slot, with first/last/vl_part_0/vl_0 flags and the gather aux_count.
// - Optionally appends a flush pass over the destination register group.
// - Sits between the vector dispatcher and the ELEM unit pipe_in handshake.

---
 rtl/vproc_elem_seq.sv | 182 ++++++++++++++++++
 tb/tb_vproc_elem_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_elem_seq.sv
// Element-slot sequencer feeding the ELEM unit: one control beat per slot, optional flush pass.
// Define VPROC_ELEM_SEQ_BACK2BACK_EN to accept the next descriptor alongside the final beat.
module vproc_elem_seq #(
  parameter int unsigned VREG_W      = 128,
  parameter int unsigned CFG_VL_W    = 7,
  parameter int unsigned GATHER_OP_W = 32,
  parameter logic [4:0]  FLUSH_OP    = 5'd8,
  localparam int unsigned AUX_W =
    ($clog2(VREG_W / GATHER_OP_W) < 1) ? 1 : $clog2(VREG_W / GATHER_OP_W)
) (
  input  logic                clk_i,
  input  logic                sync_rst_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [4:0]          instr_op_i,
  input  logic                instr_gather_i,
  input  logic                instr_flush_i,
  input  logic [1:0]          instr_eew_i,
  input  logic [4:0]          instr_vd_i,
  input  logic [CFG_VL_W:0]   instr_vl_i,
  input  logic [CFG_VL_W:0]   instr_nslots_i,
  output logic                seq_valid_o,
  input  logic                seq_ready_i,
  output logic [4:0]          seq_op_o,
  output logic [1:0]          seq_eew_o,
  output logic [4:0]          seq_vd_o,
  output logic                seq_first_o,
  output logic                seq_last_o,
  output logic                seq_vl_part_0_o,
  output logic                seq_vl_0_o,
  output logic [CFG_VL_W-1:0] seq_idx_o,
  output logic [AUX_W-1:0]    seq_aux_o,
  output logic                seq_flush_o,
  output logic                busy_o
);

  localparam logic [AUX_W-1:0]  AUX_MAX = AUX_W'(VREG_W / GATHER_OP_W - 1);
  localparam logic [CFG_VL_W:0] ONE     = (CFG_VL_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, MAIN, FLUSH} state_e;

  typedef struct packed {
    logic [4:0]          op;
    logic [1:0]          eew;
    logic [4:0]          vd;
    logic                first;
    logic                last;
    logic                vl_part_0;
    logic                vl_0;
    logic [CFG_VL_W-1:0] idx;
    logic [AUX_W-1:0]    aux;
    logic                flush;
  } beat_t;

  state_e            state_q;
  logic              valid_q;
  beat_t             beat_q;
  logic [4:0]        op_q;
  logic              gather_q;
  logic              flush_q;
  logic [1:0]        eew_q;
  logic [4:0]        vd_q;
  logic [CFG_VL_W:0] vl_q;
  logic [CFG_VL_W:0] nslots_q;
  logic [CFG_VL_W:0] idx_q;
  logic [AUX_W-1:0]  aux_q;

  logic              fire;
  logic              final_fire;
  logic              accept;
  logic              step_aux;
  logic [CFG_VL_W:0] nxt_idx;
  logic [AUX_W-1:0]  nxt_aux;

  // Flags are derived once when a beat is loaded so every output comes straight from a flop.
  function automatic beat_t make_beat(input logic [4:0]        op,
                                      input logic [1:0]        eew,
                                      input logic [4:0]        vd,
                                      input logic [CFG_VL_W:0] vl,
                                      input logic [CFG_VL_W:0] nslots,
                                      input logic [CFG_VL_W:0] idx,
                                      input logic [AUX_W-1:0]  aux,
                                      input logic              gather,
                                      input logic              flush);
    beat_t            b;
    logic [AUX_W-1:0] aux_last;
    aux_last    = gather ? AUX_MAX : '0;
    b.op        = op;
    b.eew       = eew;
    b.vd        = vd;
    b.first     = (idx == '0) && (aux == '0);
    b.last      = (idx == (nslots - ONE)) && (aux == aux_last);
    b.vl_part_0 = (idx >= vl);
    b.vl_0      = (vl == '0);
    b.idx       = idx[CFG_VL_W-1:0];
    b.aux       = aux;
    b.flush     = flush;
    return b;
  endfunction

  assign fire       = valid_q & seq_ready_i;
  assign final_fire = fire & beat_q.last & ((state_q == FLUSH) | ~flush_q);

`ifdef VPROC_ELEM_SEQ_BACK2BACK_EN
  assign instr_ready_o = (state_q == IDLE) | final_fire;
`else
  assign instr_ready_o = (state_q == IDLE);
`endif

  assign accept = instr_valid_i & instr_ready_o;

  // Gather sweeps every aux sub-beat of a slot before moving on; flush never does.
  assign step_aux = gather_q && (state_q == MAIN) && (aux_q != AUX_MAX);
  assign nxt_idx  = step_aux ? idx_q : idx_q + ONE;
  assign nxt_aux  = step_aux ? aux_q + AUX_W'(1) : '0;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      beat_q   <= '0;
      op_q     <= '0;
      gather_q <= 1'b0;
      flush_q  <= 1'b0;
      eew_q    <= '0;
      vd_q     <= '0;
      vl_q     <= '0;
      nslots_q <= '0;
      idx_q    <= '0;
      aux_q    <= '0;
    end else if (accept) begin
      op_q     <= instr_op_i;
      gather_q <= instr_gather_i;
      flush_q  <= instr_flush_i;
      eew_q    <= instr_eew_i;
      vd_q     <= instr_vd_i;
      vl_q     <= instr_vl_i;
      nslots_q <= instr_nslots_i;
      idx_q    <= '0;
      aux_q    <= '0;
      valid_q  <= 1'b1;
      state_q  <= MAIN;
      beat_q   <= make_beat(instr_op_i, instr_eew_i, instr_vd_i, instr_vl_i, instr_nslots_i,
                            '0, '0, instr_gather_i, 1'b0);
    end else if (fire) begin
      if (beat_q.last) begin
        if ((state_q == MAIN) && flush_q) begin
          state_q <= FLUSH;
          idx_q   <= '0;
          aux_q   <= '0;
          beat_q  <= make_beat(FLUSH_OP, eew_q, vd_q, vl_q, nslots_q, '0, '0, 1'b0, 1'b1);
        end else begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          beat_q  <= '0;
        end
      end else begin
        idx_q  <= nxt_idx;
        aux_q  <= nxt_aux;
        beat_q <= make_beat((state_q == FLUSH) ? FLUSH_OP : op_q, eew_q, vd_q, vl_q, nslots_q,
                            nxt_idx, nxt_aux, gather_q && (state_q == MAIN), state_q == FLUSH);
      end
    end
  end

  assign seq_valid_o     = valid_q;
  assign seq_op_o        = beat_q.op;
  assign seq_eew_o       = beat_q.eew;
  assign seq_vd_o        = beat_q.vd;
  assign seq_first_o     = beat_q.first;
  assign seq_last_o      = beat_q.last;
  assign seq_vl_part_0_o = beat_q.vl_part_0;
  assign seq_vl_0_o      = beat_q.vl_0;
  assign seq_idx_o       = beat_q.idx;
  assign seq_aux_o       = beat_q.aux;
  assign seq_flush_o     = beat_q.flush;
  assign busy_o          = (state_q != IDLE);

  nslots_nonzero: assert property (@(posedge clk_i) disable iff (sync_rst_i)
                                   accept |-> (instr_nslots_i != '0));

endmodule

// File: tb/tb_vproc_elem_seq.sv
// Directed bench for vproc_elem_seq: beat ordering, flags, stalls, reset and back-to-back issue.
module tb_vproc_elem_seq;

  localparam bit B2B =
`ifdef VPROC_ELEM_SEQ_BACK2BACK_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk;
  logic       sync_rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] instr_op;
  logic       instr_gather;
  logic       instr_flush;
  logic [1:0] instr_eew;
  logic [4:0] instr_vd;
  logic [7:0] instr_vl;
  logic [7:0] instr_nslots;
  logic       seq_valid;
  logic       seq_ready;
  logic [4:0] seq_op;
  logic [1:0] seq_eew;
  logic [4:0] seq_vd;
  logic       seq_first;
  logic       seq_last;
  logic       seq_vl_part_0;
  logic       seq_vl_0;
  logic [6:0] seq_idx;
  logic [1:0] seq_aux;
  logic       seq_flush;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  vproc_elem_seq dut (
    .clk_i           (clk),
    .sync_rst_i      (sync_rst),
    .instr_valid_i   (instr_valid),
    .instr_ready_o   (instr_ready),
    .instr_op_i      (instr_op),
    .instr_gather_i  (instr_gather),
    .instr_flush_i   (instr_flush),
    .instr_eew_i     (instr_eew),
    .instr_vd_i      (instr_vd),
    .instr_vl_i      (instr_vl),
    .instr_nslots_i  (instr_nslots),
    .seq_valid_o     (seq_valid),
    .seq_ready_i     (seq_ready),
    .seq_op_o        (seq_op),
    .seq_eew_o       (seq_eew),
    .seq_vd_o        (seq_vd),
    .seq_first_o     (seq_first),
    .seq_last_o      (seq_last),
    .seq_vl_part_0_o (seq_vl_part_0),
    .seq_vl_0_o      (seq_vl_0),
    .seq_idx_o       (seq_idx),
    .seq_aux_o       (seq_aux),
    .seq_flush_o     (seq_flush),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expBeat(input logic [4:0] op, input int idx, input int aux,
                                          input bit first, input bit last, input bit vlp0,
                                          input bit vl0, input bit flush);
    return {12'd0, 1'b1, op, idx[6:0], aux[1:0], first, last, vlp0, vl0, flush};
  endfunction

  function automatic logic [31:0] obsBeat();
    return {12'd0, seq_valid, seq_op, seq_idx, seq_aux, seq_first, seq_last,
            seq_vl_part_0, seq_vl_0, seq_flush};
  endfunction

  // Compare the beat on display, then move to the next negedge (beat consumed if ready is high).
  task automatic checkBeat(input string tag, input logic [31:0] expected);
    checkOutput(tag, obsBeat(), expected);
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, {29'd0, busy, seq_valid, instr_ready}, 32'b001);
  endtask

  task automatic waitAccept(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      #1;
      if (instr_ready) ok = 1'b1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    checkOutput(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic gather, input logic flush,
                               input logic [1:0] eew, input logic [4:0] vd,
                               input logic [7:0] vl, input logic [7:0] nslots);
    instr_op     = op;
    instr_gather = gather;
    instr_flush  = flush;
    instr_eew    = eew;
    instr_vd     = vd;
    instr_vl     = vl;
    instr_nslots = nslots;
    instr_valid  = 1'b1;
    waitAccept($sformatf("accept_op%0d", op));
  endtask

  initial begin
    bit acc1;
    sync_rst     = 1'b1;
    instr_valid  = 1'b0;
    instr_op     = '0;
    instr_gather = 1'b0;
    instr_flush  = 1'b0;
    instr_eew    = '0;
    instr_vd     = '0;
    instr_vl     = '0;
    instr_nslots = 8'd1;
    seq_ready    = 1'b1;
    repeat (2) @(negedge clk);
    checkIdle("reset_ctrl");
    checkOutput("reset_data", obsBeat(), 32'd0);
    sync_rst = 1'b0;
    @(negedge clk);

    // Reduction: vl 3 over 4 slots
    applyStimulus(5'd1, 1'b0, 1'b0, 2'd2, 5'd17, 8'd3, 8'd4);
    checkOutput("redsum_eew_vd", {25'd0, seq_eew, seq_vd}, {25'd0, 2'd2, 5'd17});
    for (int i = 0; i < 4; i++)
      checkBeat($sformatf("redsum_beat%0d", i), expBeat(5'd1, i, 0, i == 0, i == 3, i >= 3, 0, 0));
    checkIdle("redsum_idle");

    // Gather: 4 aux sub-beats per slot, vl 1 so slot 1 is past vl
    applyStimulus(5'd12, 1'b1, 1'b0, 2'd0, 5'd4, 8'd1, 8'd2);
    for (int b = 0; b < 8; b++)
      checkBeat($sformatf("gather_beat%0d", b),
                expBeat(5'd12, b / 4, b % 4, b == 0, b == 7, (b / 4) >= 1, 0, 0));
    checkIdle("gather_idle");

    // Compress with flush pass
    applyStimulus(5'd3, 1'b0, 1'b1, 2'd1, 5'd9, 8'd2, 8'd4);
    for (int i = 0; i < 4; i++)
      checkBeat($sformatf("compress_main%0d", i),
                expBeat(5'd3, i, 0, i == 0, i == 3, i >= 2, 0, 0));
    for (int i = 0; i < 4; i++)
      checkBeat($sformatf("compress_flush%0d", i),
                expBeat(5'd8, i, 0, i == 0, i == 3, i >= 2, 0, 1));
    checkIdle("compress_idle");

    // vl = 0: every slot is past vl
    applyStimulus(5'd4, 1'b0, 1'b0, 2'd0, 5'd1, 8'd0, 8'd4);
    for (int i = 0; i < 4; i++)
      checkBeat($sformatf("vl0_beat%0d", i), expBeat(5'd4, i, 0, i == 0, i == 3, 1, 1, 0));
    checkIdle("vl0_idle");

    // Downstream stall on idx 2 for three cycles
    applyStimulus(5'd1, 1'b0, 1'b0, 2'd0, 5'd2, 8'd4, 8'd4);
    checkBeat("stall_beat0", expBeat(5'd1, 0, 0, 1, 0, 0, 0, 0));
    checkBeat("stall_beat1", expBeat(5'd1, 1, 0, 0, 0, 0, 0, 0));
    checkOutput("stall_beat2", obsBeat(), expBeat(5'd1, 2, 0, 0, 0, 0, 0, 0));
    seq_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_hold%0d", s), obsBeat(), expBeat(5'd1, 2, 0, 0, 0, 0, 0, 0));
    end
    seq_ready = 1'b1;
    @(negedge clk);
    checkBeat("stall_beat3", expBeat(5'd1, 3, 0, 0, 1, 0, 0, 0));
    checkIdle("stall_idle");

    // Reset in the middle of an instruction
    applyStimulus(5'd1, 1'b0, 1'b0, 2'd0, 5'd2, 8'd4, 8'd4);
    checkBeat("rst_beat0", expBeat(5'd1, 0, 0, 1, 0, 0, 0, 0));
    checkOutput("rst_beat1", obsBeat(), expBeat(5'd1, 1, 0, 0, 0, 0, 0, 0));
    sync_rst = 1'b1;
    @(negedge clk);
    checkIdle("rst_mid_ctrl");
    checkOutput("rst_mid_data", obsBeat(), 32'd0);
    sync_rst = 1'b0;
    applyStimulus(5'd6, 1'b0, 1'b0, 2'd0, 5'd2, 8'd1, 8'd2);
    checkBeat("rst_new0", expBeat(5'd6, 0, 0, 1, 0, 0, 0, 0));
    checkBeat("rst_new1", expBeat(5'd6, 1, 0, 0, 1, 1, 0, 0));
    checkIdle("rst_new_idle");

    // Two single-slot instructions issued back to back
    applyStimulus(5'd1, 1'b0, 1'b0, 2'd0, 5'd0, 8'd1, 8'd1);
    checkOutput("b2b_a", obsBeat(), expBeat(5'd1, 0, 0, 1, 1, 0, 0, 0));
    instr_op    = 5'd5;
    instr_valid = 1'b1;
    #1;
    acc1 = instr_ready;
    checkOutput("b2b_ready", {31'd0, instr_ready}, {31'd0, B2B});
    @(negedge clk);
    checkOutput("b2b_gap", {31'd0, seq_valid}, {31'd0, B2B});
    if (acc1) instr_valid = 1'b0;
    else waitAccept("b2b_accept");
    for (int c = 0; c < 4 && !seq_valid; c++) @(negedge clk);
    checkBeat("b2b_b", expBeat(5'd5, 0, 0, 1, 1, 0, 0, 0));
    checkIdle("b2b_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
